// File: rtl/ldpc_dec_ctrl.sv
// LDPC decoder sequencer: drives the shared phase code to the column cells
// and counts load, check-node, variable-node and output cycles per frame.
module ldpc_dec_ctrl #(
  parameter int A_WID      = 8,
  parameter int LOAD_LEN   = 256,
  parameter int CN_LEN_R12 = 144,
  parameter int CN_LEN_R34 = 72,
  parameter int VN_LEN     = 256,
  parameter int OUT_LEN    = 256,
  parameter int IT_WID     = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              frame_start,
  input  logic              code_rate_in,
  input  logic [IT_WID-1:0] max_iter,
  input  logic              sync_in,
  input  logic              parity_ok,
  output logic [3:0]        fsm,
  output logic              code_rate,
  output logic [A_WID-1:0]  phase_cnt,
  output logic [IT_WID-1:0] iter_cnt,
  output logic              busy,
  output logic              out_valid,
  output logic              dec_done,
  output logic              early_stop,
  output logic              overrun
);

  typedef enum logic [3:0] {
    S_IDLE = 4'b0000,
    S_LOAD = 4'b0010,
    S_CHK  = 4'b0100,
    S_VAR  = 4'b1000,
    S_OUT  = 4'b0001
  } state_e;

  localparam logic [A_WID-1:0] LOAD_LAST = A_WID'(LOAD_LEN - 1);
  localparam logic [A_WID-1:0] CN12_LAST = A_WID'(CN_LEN_R12 - 1);
  localparam logic [A_WID-1:0] CN34_LAST = A_WID'(CN_LEN_R34 - 1);
  localparam logic [A_WID-1:0] VN_LAST   = A_WID'(VN_LEN - 1);
  localparam logic [A_WID-1:0] OUT_LAST  = A_WID'(OUT_LEN - 1);
  localparam logic [IT_WID-1:0] IT_MAX   = {IT_WID{1'b1}};

  state_e              state_q, state_d;
  logic                tail_q, tail_d;
  logic                code_rate_q, code_rate_d;
  logic [IT_WID-1:0]   budget_q, budget_d;
  logic [A_WID-1:0]    phase_cnt_q, phase_cnt_d;
  logic [IT_WID-1:0]   iter_cnt_q, iter_cnt_d;
  logic                busy_q, busy_d;
  logic                out_valid_q, out_valid_d;
  logic                dec_done_q, dec_done_d;
  logic                early_stop_q, early_stop_d;
  logic                overrun_q, overrun_d;
  logic [IT_WID-1:0]   iter_inc;
  logic [A_WID-1:0]    cn_last;

  always_comb begin
    state_d      = state_q;
    tail_d       = tail_q;
    code_rate_d  = code_rate_q;
    budget_d     = budget_q;
    phase_cnt_d  = phase_cnt_q;
    iter_cnt_d   = iter_cnt_q;
    early_stop_d = early_stop_q;
    dec_done_d   = 1'b0;
    overrun_d    = frame_start && (state_q != S_IDLE);
    iter_inc     = (iter_cnt_q == IT_MAX) ? iter_cnt_q
                                          : iter_cnt_q + 1'b1;
    cn_last      = code_rate_q ? CN34_LAST : CN12_LAST;

    unique case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d      = S_LOAD;
          code_rate_d  = code_rate_in;
          budget_d     = (max_iter == '0) ? IT_WID'(1) : max_iter;
          phase_cnt_d  = '0;
          iter_cnt_d   = '0;
          early_stop_d = 1'b0;
          tail_d       = 1'b0;
        end
      end
      S_LOAD: begin
        // tail cycle lets the cells' registered write land
        if (tail_q) begin
          state_d     = S_CHK;
          phase_cnt_d = '0;
          tail_d      = 1'b0;
        end else if (sync_in) begin
          phase_cnt_d = phase_cnt_q + 1'b1;
          tail_d      = (phase_cnt_q == LOAD_LAST);
        end
      end
      S_CHK: begin
        if (phase_cnt_q == cn_last) begin
          state_d     = S_VAR;
          phase_cnt_d = '0;
        end else begin
          phase_cnt_d = phase_cnt_q + 1'b1;
        end
      end
      S_VAR: begin
        if (phase_cnt_q == VN_LAST) begin
          phase_cnt_d = '0;
          iter_cnt_d  = iter_inc;
          if (parity_ok) begin
            state_d      = S_OUT;
            early_stop_d = 1'b1;
          end else if (iter_inc == budget_q) begin
            state_d = S_OUT;
          end else begin
            state_d = S_CHK;
          end
        end else begin
          phase_cnt_d = phase_cnt_q + 1'b1;
        end
      end
      S_OUT: begin
        if (phase_cnt_q == OUT_LAST) begin
          state_d     = S_IDLE;
          phase_cnt_d = '0;
          dec_done_d  = 1'b1;
        end else begin
          phase_cnt_d = phase_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        phase_cnt_d = '0;
        tail_d      = 1'b0;
      end
    endcase

    busy_d      = (state_d != S_IDLE);
    out_valid_d = (state_d == S_OUT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      tail_q       <= 1'b0;
      code_rate_q  <= 1'b0;
      budget_q     <= '0;
      phase_cnt_q  <= '0;
      iter_cnt_q   <= '0;
      busy_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      dec_done_q   <= 1'b0;
      early_stop_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tail_q       <= tail_d;
      code_rate_q  <= code_rate_d;
      budget_q     <= budget_d;
      phase_cnt_q  <= phase_cnt_d;
      iter_cnt_q   <= iter_cnt_d;
      busy_q       <= busy_d;
      out_valid_q  <= out_valid_d;
      dec_done_q   <= dec_done_d;
      early_stop_q <= early_stop_d;
      overrun_q    <= overrun_d;
    end
  end

  assign fsm        = state_q;
  assign code_rate  = code_rate_q;
  assign phase_cnt  = phase_cnt_q;
  assign iter_cnt   = iter_cnt_q;
  assign busy       = busy_q;
  assign out_valid  = out_valid_q;
  assign dec_done   = dec_done_q;
  assign early_stop = early_stop_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_ldpc_dec_ctrl.sv
// Bench for ldpc_dec_ctrl: random frames checked against a
// schedule derived from phase lengths and the stop rules.
module tb_ldpc_dec_ctrl;

  localparam int A_WID    = 8;
  localparam int IT_WID   = 5;
  localparam int LOAD_LEN = 256;
  localparam int CN12     = 144;
  localparam int CN34     = 72;
  localparam int VN_LEN   = 256;
  localparam int OUT_LEN  = 256;

  localparam logic [3:0] F_IDLE = 4'b0000;
  localparam logic [3:0] F_LOAD = 4'b0010;
  localparam logic [3:0] F_CHK  = 4'b0100;
  localparam logic [3:0] F_VAR  = 4'b1000;
  localparam logic [3:0] F_OUT  = 4'b0001;

  logic              clk;
  logic              reset_n;
  logic              frame_start;
  logic              code_rate_in;
  logic [IT_WID-1:0] max_iter;
  logic              sync_in;
  logic              parity_ok;
  logic [3:0]        fsm;
  logic              code_rate;
  logic [A_WID-1:0]  phase_cnt;
  logic [IT_WID-1:0] iter_cnt;
  logic              busy;
  logic              out_valid;
  logic              dec_done;
  logic              early_stop;
  logic              overrun;

  int checks = 0;
  int errors = 0;
  int done_t;

  ldpc_dec_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .frame_start  (frame_start),
    .code_rate_in (code_rate_in),
    .max_iter     (max_iter),
    .sync_in      (sync_in),
    .parity_ok    (parity_ok),
    .fsm          (fsm),
    .code_rate    (code_rate),
    .phase_cnt    (phase_cnt),
    .iter_cnt     (iter_cnt),
    .busy         (busy),
    .out_valid    (out_valid),
    .dec_done     (dec_done),
    .early_stop   (early_stop),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_fsm"}, 32'(fsm), 0);
    chk({tag, "_ph"}, 32'(phase_cnt), 0);
    chk({tag, "_it"}, 32'(iter_cnt), 0);
    chk({tag, "_flags"},
        32'({code_rate, busy, out_valid, dec_done, early_stop, overrun}), 0);
  endtask

  // t is the offset from the first LOAD cycle
  task automatic run_frame(input logic rate, input int mi, input int gap,
                           input int p, input int os1, input int os2,
                           input int abort_t, output int dt);
    int bud, nit, cn, per, tl, tc, tend, tt, t2;
    bit es, eearly, edone, eov, eoutv;
    logic [3:0] efsm;
    int eph, eit;
    dt = -1;
    bud = (mi == 0) ? 1 : mi;
    es = (p != 0) && (p <= bud);
    nit = es ? p : bud;
    cn = rate ? CN34 : CN12;
    per = cn + VN_LEN;
    tl = (LOAD_LEN - 1) * gap;
    tc = tl + 2;
    tend = tc + nit * per + OUT_LEN + 1;
    frame_start = 1'b1;
    code_rate_in = rate;
    max_iter = IT_WID'(mi);
    sync_in = 1'b0;
    parity_ok = 1'($urandom);
    tick();
    for (int t = 0; t <= tend; t++) begin
      tt = t - tc;
      t2 = tt - nit * per;
      edone = 1'b0;
      eoutv = 1'b0;
      if (t < tc) begin
        efsm = F_LOAD;
        eph = ((t + gap - 1) / gap) % (1 << A_WID);
        eit = 0;
        eearly = 1'b0;
      end else if (tt < nit * per) begin
        if (tt % per < cn) begin
          efsm = F_CHK;
          eph = tt % per;
        end else begin
          efsm = F_VAR;
          eph = tt % per - cn;
        end
        eit = tt / per;
        eearly = 1'b0;
      end else if (t2 < OUT_LEN) begin
        efsm = F_OUT;
        eph = t2;
        eit = nit;
        eearly = es;
        eoutv = 1'b1;
      end else begin
        efsm = F_IDLE;
        eph = 0;
        eit = nit;
        eearly = es;
        edone = (t2 == OUT_LEN);
      end
      eov = (os1 >= 0 && t == os1 + 1) || (os2 >= 0 && t == os2 + 1);
      chk("fsm", 32'(fsm), 32'(efsm));
      chk("phase_cnt", 32'(phase_cnt), eph);
      chk("iter_cnt", 32'(iter_cnt), eit);
      chk("busy", 32'(busy), 32'(efsm != F_IDLE));
      chk("out_valid", 32'(out_valid), 32'(eoutv));
      chk("dec_done", 32'(dec_done), 32'(edone));
      chk("early_stop", 32'(early_stop), 32'(eearly));
      chk("overrun", 32'(overrun), 32'(eov));
      chk("code_rate", 32'(code_rate), 32'(rate));
      if (dec_done && dt < 0) dt = t;
      if (t == abort_t) begin
        #2 reset_n = 1'b0;
        #1 chk_zero("rst_mid");
        frame_start = 1'b0;
        sync_in = 1'b0;
        @(negedge clk);
        chk_zero("rst_hold");
        reset_n = 1'b1;
        tick();
        return;
      end
      if (t <= tl) sync_in = (t % gap == 0);
      else if (t == tl + 1) sync_in = 1'b1;
      else sync_in = 1'($urandom);
      if (t >= tc && tt < nit * per && tt % per == per - 1)
        parity_ok = (tt / per + 1 == p);
      else
        parity_ok = 1'($urandom);
      frame_start = (t == os1) || (t == os2);
      code_rate_in = 1'($urandom);
      max_iter = IT_WID'($urandom);
      tick();
    end
    frame_start = 1'b0;
    sync_in = 1'b0;
  endtask

  initial begin
    int mi, p, g;
    logic r;
    reset_n = 1'b0;
    frame_start = 1'b0;
    code_rate_in = 1'b0;
    max_iter = '0;
    sync_in = 1'b0;
    parity_ok = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_zero("rst");
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    run_frame(1'b0, 3, 1, 0, -1, -1, -1, done_t);
    chk("lat_full_r12", done_t, 1713);

    run_frame(1'b1, 10, 1, 2, -1, -1, -1, done_t);
    chk("lat_early_r34", done_t, 257 + 2 * (CN34 + VN_LEN) + OUT_LEN);

    run_frame(1'($urandom), 1, 3, 0, -1, -1, -1, done_t);

    run_frame(1'b0, 1, 1, 0, 257 + 5, 257 + CN12 + VN_LEN + OUT_LEN - 1,
              -1, done_t);
    chk("lat_overrun", done_t, 257 + CN12 + VN_LEN + OUT_LEN);

    run_frame(1'b1, 0, 1, 0, -1, -1, -1, done_t);
    chk("lat_zero_budget", done_t, 257 + CN34 + VN_LEN + OUT_LEN);

    run_frame(1'b0, 2, 1, 0, -1, -1, 257 + CN12 + VN_LEN + CN12 + 10,
              done_t);

    run_frame(1'b0, 2, 1, 1, -1, -1, -1, done_t);
    chk("lat_after_rst", done_t, 257 + CN12 + VN_LEN + OUT_LEN);

    for (int k = 0; k < 3; k++) begin
      r = 1'($urandom);
      mi = $urandom_range(0, 3);
      p = $urandom_range(0, 3);
      g = $urandom_range(1, 2);
      run_frame(r, mi, g, p, -1, -1, -1, done_t);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
